// File: rtl/instruction_fetch_unit.sv
// Prefetch stage: forms segment:offset fetch addresses, reads instruction words over a
// req/ack port into a small FIFO, and hands them to decode over a valid/ready handshake.
module instruction_fetch_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 20,
  parameter int SEG_SHIFT = 4,
  parameter int QDEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             ip_in,
  input  logic [15:0]             isr_in,
  input  logic                    redirect,
  input  logic [15:0]             redirect_ip,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [DATA_W-1:0]       instr_out,
  output logic [15:0]             instr_ip,
  output logic                    inc_ip,
  output logic                    update_count,
  output logic                    count_access,
  output logic [$clog2(QDEPTH):0] q_level
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SUM_W = (16 + SEG_SHIFT > ADDR_W) ? 16 + SEG_SHIFT : ADDR_W;

  typedef enum logic [1:0] {ST_START, ST_IDLE, ST_REQ, ST_DISCARD} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [15:0]       r_fetch_ip;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_q_data [QDEPTH];
  logic [15:0]       r_q_ip   [QDEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_count_access;

  logic [SUM_W-1:0]  w_sum;
  logic [ADDR_W-1:0] w_live_addr;
  logic              w_push;
  logic              w_pop;
  logic              w_space;

  assign w_sum       = SUM_W'({isr_in, {SEG_SHIFT{1'b0}}}) + SUM_W'(r_fetch_ip);
  assign w_live_addr = w_sum[ADDR_W-1:0];
  assign w_space     = (r_level < LVL_W'(QDEPTH));
  // Redirect wins: an ack that coincides with it is dropped, and no word is consumed.
  assign w_push      = (r_state == ST_REQ) && mem_ack && !redirect;
  assign w_pop       = instr_valid && instr_ready && !redirect;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_START;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the value unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      ST_START:   w_next_state = ST_IDLE;
      ST_IDLE:    if (!redirect && w_space) w_next_state = ST_REQ;
      ST_REQ: begin
        if (mem_ack)       w_next_state = ST_IDLE;
        else if (redirect) w_next_state = ST_DISCARD;
      end
      ST_DISCARD: if (mem_ack) w_next_state = ST_IDLE;
      default:    w_next_state = ST_START;
    endcase
  end

  // A discarded request keeps presenting the address it was issued with.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    case (r_state)
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_addr = w_live_addr;
      end
      ST_DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = r_hold_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_ip  <= '0;
      r_hold_addr <= '0;
    end else begin
      if (redirect)                  r_fetch_ip <= redirect_ip;
      else if (r_state == ST_START)  r_fetch_ip <= ip_in;
      else if (w_push)               r_fetch_ip <= r_fetch_ip + 16'd1;
      if (r_state == ST_REQ && redirect && !mem_ack) r_hold_addr <= w_live_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the queue storage is small and drives outputs directly, so it is reset to keep instr_out/instr_ip at 0.
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_ip[i]   <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_q_data[r_wr_ptr] <= mem_rdata;
        r_q_ip[r_wr_ptr]   <= r_fetch_ip;
        r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count_access <= 1'b0;
    else        r_count_access <= mem_req && mem_ack;
  end

  assign instr_valid  = (r_level != '0);
  assign instr_out    = r_q_data[r_rd_ptr];
  assign instr_ip     = r_q_ip[r_rd_ptr];
  assign inc_ip       = w_pop;
  assign update_count = w_pop;
  assign count_access = r_count_access;
  assign q_level      = r_level;

endmodule
